// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and types for the 4-way round-robin mux arbiter.
package mux_rr_arbiter_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    typedef logic [ID_W-1:0]  req_idx_t;
    typedef logic [N_REQ-1:0] req_vec_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester and downstream handshake bundle for mux_rr_arbiter.
interface mux_rr_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    import mux_rr_arbiter_pkg::*;

    req_vec_t                 in_valid;
    logic [N_REQ*WIDTH-1:0]   in_data;
    req_vec_t                 in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    req_idx_t                 out_id;

    // The arbiter side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_id
    );

    // The environment side: requesters plus downstream consumer.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_id
    );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping 3 -> 0.
module rr_pick
    import mux_rr_arbiter_pkg::*;
(
    input  req_vec_t valid,
    input  req_idx_t ptr,
    output req_vec_t grant,
    output req_idx_t idx
);

    always_comb begin
        req_idx_t cand;
        logic     found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + req_idx_t'(k);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// 4-requester round-robin arbiter feeding a single registered output word.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_arbiter_if.slave   bus
);

    req_idx_t         ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    req_idx_t         id_q, id_d;

    req_vec_t grant;
    req_idx_t gidx;
    logic     free;
    logic     take;

    rr_pick u_pick (
        .valid (bus.in_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gidx)
    );

    assign free         = !valid_q || bus.out_ready;
    assign bus.in_ready = (rst || !free) ? '0 : grant;
    assign take         = |bus.in_ready;

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        if (take) begin
            data_d  = bus.in_data[int'(gidx)*WIDTH +: WIDTH];
            id_d    = gidx;
            valid_d = 1'b1;
            ptr_d   = gidx + req_idx_t'(1);
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_id    = id_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter.
module tb_mux_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mux_rr_arbiter_if #(.WIDTH(8)) bus ();

    mux_rr_arbiter #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] dval [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dval[0] = 8'h11; dval[1] = 8'h22; dval[2] = 8'h33; dval[3] = 8'h44;
        rst          = 1'b1;
        bus.in_valid = 4'b0000;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        tick();
        // in_ready must stay low under reset even with everyone requesting
        bus.in_valid = 4'b1111;
        #1 check("rst_in_ready_busy", 32'(bus.in_ready), 32'h0);
        bus.in_valid = 4'b0000;
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_out_id",    32'(bus.out_id),    32'h0);
        check("rst_in_ready",  32'(bus.in_ready),  32'h0);

        // Single requester 2
        rst           = 1'b0;
        bus.in_valid  = 4'b0100;
        bus.in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
        bus.out_ready = 1'b1;
        #1 check("single_in_ready", 32'(bus.in_ready), 32'h4);
        tick();
        check("single_out_valid", 32'(bus.out_valid), 32'h1);
        check("single_out_data",  32'(bus.out_data),  32'hA5);
        check("single_out_id",    32'(bus.out_id),    32'h2);

        // Drain with no new input
        bus.in_valid = 4'b0000;
        bus.in_data  = {dval[3], dval[2], dval[1], dval[0]};
        tick();
        check("drain_out_valid", 32'(bus.out_valid), 32'h0);

        // ptr=3, requesters 0 and 3: 3 first, then 0
        bus.in_valid = 4'b1001;
        #1 check("wrap_in_ready3", 32'(bus.in_ready), 32'h8);
        tick();
        check("wrap_id3",   32'(bus.out_id),   32'h3);
        check("wrap_data3", 32'(bus.out_data), 32'h44);
        #1 check("wrap_in_ready0", 32'(bus.in_ready), 32'h1);
        tick();
        check("wrap_id0", 32'(bus.out_id), 32'h0);

        // Bring ptr to 3 via requester 2, then only requester 1 valid
        bus.in_valid = 4'b0100;
        tick();
        check("skip_pre_id", 32'(bus.out_id), 32'h2);
        bus.in_valid = 4'b0010;
        #1 check("skip_in_ready", 32'(bus.in_ready), 32'h2);
        tick();
        check("skip_id",   32'(bus.out_id),   32'h1);
        check("skip_data", 32'(bus.out_data), 32'h22);

        // Bring ptr to 0 via requester 3, then fairness sweep
        bus.in_valid = 4'b1000;
        tick();
        bus.in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 check($sformatf("fair_in_ready%0d", k), 32'(bus.in_ready), 32'(1 << (k % 4)));
            tick();
            check($sformatf("fair_valid%0d", k), 32'(bus.out_valid), 32'h1);
            check($sformatf("fair_id%0d", k),    32'(bus.out_id),    32'(k % 4));
            check($sformatf("fair_data%0d", k),  32'(bus.out_data),  32'(dval[k % 4]));
        end

        // Backpressure: word from requester 3 held, ptr stays 0
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("bp_in_ready%0d", k), 32'(bus.in_ready), 32'h0);
            tick();
            check($sformatf("bp_valid%0d", k), 32'(bus.out_valid), 32'h1);
            check($sformatf("bp_id%0d", k),    32'(bus.out_id),    32'h3);
            check($sformatf("bp_data%0d", k),  32'(bus.out_data),  32'h44);
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check("bp_release_id",   32'(bus.out_id),   32'h0);
        check("bp_release_data", 32'(bus.out_data), 32'h11);

        // Reset during a stall discards the held word and resets ptr
        bus.out_ready = 1'b0;
        tick();
        check("stall_valid", 32'(bus.out_valid), 32'h1);
        rst = 1'b1;
        #1 check("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_data",  32'(bus.out_data),  32'h0);
        check("mid_rst_id",    32'(bus.out_id),    32'h0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        #1 check("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check("post_rst_id",   32'(bus.out_id),   32'h0);
        check("post_rst_data", 32'(bus.out_data), 32'h11);
        bus.in_valid = 4'b0000;
        tick();
        check("post_rst_drain", 32'(bus.out_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width of every requester and of the output.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 The block SHALL have port in_valid  input  4  per-requester valid, bit i = requester i.
REQ-005 The block SHALL have port in_data  input  4*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-006 The block SHALL have port in_ready  output  4  per-requester accept, at most one bit high per cycle.
REQ-007 The block SHALL have port out_valid  output  1  output register holds a word.
REQ-008 The block SHALL have port out_ready  input  1  downstream accepts the word this cycle.
REQ-009 The block SHALL have port out_data  output  WIDTH  registered selected word.
REQ-010 The block SHALL have port out_id  output  2  index of the requester that supplied out_data.

Function
REQ-011 Transfers SHALL occur on in_valid[i] && in_ready[i] (input) and out_valid && out_ready (output).
REQ-012 Arbitration SHALL be round-robin over 4 requesters; priority search starts at ptr and wraps 3 -> 0.
REQ-013 grant SHALL be one-hot: the first requester with in_valid set, searching from ptr; all-zero if no in_valid.
REQ-014 Output stage SHALL be free when !out_valid || out_ready.
REQ-015 in_ready SHALL equal grant when the output stage is free, else 4'b0000.
REQ-016 On an input transfer from requester g: out_data <= in_data[g], out_id <= g, out_valid <= 1, ptr <= (g+1) mod 4.
REQ-017 Latency SHALL be exactly 1 cycle from input transfer to out_valid.
REQ-018 On output transfer with no input transfer the same cycle, out_valid SHALL go 0.
REQ-019 Simultaneous output and input transfer SHALL load the new word; sustained throughput 1 word/cycle.
REQ-020 While out_valid && !out_ready, out_data and out_id SHALL hold stable and ptr SHALL not change.
REQ-021 ptr SHALL change only on an input transfer; idle cycles and stalls leave it unchanged.
REQ-022 A requester deasserting in_valid before acceptance SHALL lose nothing and SHALL not advance ptr.
REQ-023 With all 4 requesters continuously valid and out_ready=1, grants SHALL cycle 0,1,2,3,0,...
REQ-024 in_data of non-granted requesters SHALL have no effect on any output.

Reset
REQ-025 During rst: out_valid=0, out_data=0, out_id=0, ptr=0 (requester 0 highest priority).
REQ-026 in_ready SHALL be 4'b0000 in any cycle where rst is high.
REQ-027 Reset mid-operation SHALL discard any held output word; no transfer completes in that cycle.

Structure
REQ-028 A shared package SHALL define N_REQ=4, ID_W=2 and the requester-index typedef.
REQ-029 One combinational sub-module rr_pick SHALL compute one-hot grant and encoded index from in_valid and ptr.
REQ-030 Output register and ptr SHALL live in mux_rr_arbiter; target size 120-400 lines of RTL.

Verification
REQ-031 Reset then idle: rst=1 2 cycles, all in_valid=0 -> out_valid=0, out_data=0, in_ready=0000, ptr=0.
REQ-032 Single requester: in_valid=0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=0100; next cycle out_valid=1, out_data=A5, out_id=2.
REQ-033 Fairness: in_valid=1111 with distinct data, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3 with no gaps.
REQ-034 Backpressure: word held with out_ready=0 for 3 cycles, in_valid=1111 -> in_ready=0000, out_data/out_id stable; first cycle out_ready=1 accepts next requester.
REQ-035 Wrap and skip: ptr=3, in_valid=1001 -> requester 3 granted, then requester 0; with in_valid=0010, ptr=3 -> requester 1 granted.
REQ-036 Reset mid-stall: out_valid=1, out_ready=0, assert rst -> next cycle out_valid=0, ptr=0, held word never delivered.
